// File: rtl/io_bus_arb_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
package io_bus_arb_pkg;

  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned ACCESS_CYCLES_DEF = 2;

  // Master indices; a single bit selects between the two masters.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Request payload captured from the granted master.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } io_req_t;

endpackage

// File: rtl/io_arb_picker.sv
// Two-way grant picker: round-robin by default, fixed m0 priority when
// IO_BUS_ARB_FIXED_PRIO_EN is defined.
module io_arb_picker
  import io_bus_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_c,
  output logic valid_c
);

`ifdef IO_BUS_ARB_FIXED_PRIO_EN
  // Last grant is irrelevant when m0 always wins.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Pick a master; contention is resolved by priority mode.
  always_comb begin
    valid_c = req0_i | req1_i;
    grant_c = M0;
    if (req0_i && req1_i) begin
`ifdef IO_BUS_ARB_FIXED_PRIO_EN
      grant_c = M0;
`else
      grant_c = ~last_grant_i;
`endif
    end else if (req1_i) begin
      grant_c = M1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates two masters onto one shared IO bus, holding the strobe for
// ACCESS_CYCLES cycles and returning a one-cycle ack.
// Optional macro: IO_BUS_ARB_FIXED_PRIO_EN (m0 always wins contention).
module io_bus_arbiter
  import io_bus_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
)
(
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              io_rd,
  output logic              io_wr,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dout,
  input  logic [DATA_W-1:0] io_din
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              io_rd_q, io_rd_d;
  logic              io_wr_q, io_wr_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_dout_q, io_dout_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic [DATA_W-1:0] capture_c;

  logic    grant_c;
  logic    grant_valid_c;
  io_req_t sel_req_c;

  io_arb_picker u_picker (
    .req0_i      (m0_req),
    .req1_i      (m1_req),
    .last_grant_i(last_grant_q),
    .grant_c     (grant_c),
    .valid_c     (grant_valid_c)
  );

  // Payload of whichever master the picker selected.
  always_comb begin
    if (grant_c == M1) begin
      sel_req_c = '{addr: m1_addr, wdata: m1_wdata, rd: m1_rd, wr: m1_wr};
    end else begin
      sel_req_c = '{addr: m0_addr, wdata: m0_wdata, rd: m0_rd, wr: m0_wr};
    end
  end

  // Read data captured on the last access cycle; writes and no-ops return 0.
  always_comb begin
    capture_c = io_rd_q ? io_din : '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    io_rd_d      = io_rd_q;
    io_wr_d      = io_wr_q;
    io_addr_d    = io_addr_q;
    io_dout_d    = io_dout_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          state_d      = ACCESS;
          cnt_d        = '0;
          last_grant_d = grant_c;
          io_addr_d    = sel_req_c.addr;
          io_dout_d    = sel_req_c.wdata;
          // rd+wr together is treated as a write.
          io_rd_d      = sel_req_c.rd & ~sel_req_c.wr;
          io_wr_d      = sel_req_c.wr;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ACK;
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          if (last_grant_q == M1) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = capture_c;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = capture_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        io_rd_d = 1'b0;
        io_wr_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills strobes immediately.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= M1;
      io_rd_q      <= 1'b0;
      io_wr_q      <= 1'b0;
      io_addr_q    <= '0;
      io_dout_q    <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      io_rd_q      <= io_rd_d;
      io_wr_q      <= io_wr_d;
      io_addr_q    <= io_addr_d;
      io_dout_q    <= io_dout_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign io_rd    = io_rd_q;
  assign io_wr    = io_wr_q;
  assign io_addr  = io_addr_q;
  assign io_dout  = io_dout_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with an ack scoreboard.
// Honours IO_BUS_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_io_bus_arbiter;

  localparam int unsigned AC  = 2;
  localparam logic [15:0] KEY = 16'h7536;

  logic        sys_clk_i, sys_rst_i;
  logic        m0_req, m0_rd, m0_wr, m1_req, m1_rd, m1_wr;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;

  io_bus_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
    .io_din(io_din)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  // Peripheral model: read data is a fixed function of the bus address.
  always_comb io_din = io_addr ^ KEY;

  typedef struct {
    logic        m;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks, n_pass, n_ack, n_ack1;
  logic [15:0] model_rdata [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic m, input logic [15:0] rdata);
    exp_t e;
    e.m = m;
    e.rdata = rdata;
    exp_q.push_back(e);
    model_rdata[m] = rdata;
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  task automatic mon();
    exp_t e;
    if (!sys_rst_i && (m0_ack || m1_ack)) begin
      n_ack++;
      if (m1_ack) n_ack1++;
      chk("ack_onehot", {m0_ack, m1_ack}, m1_ack ? 32'd1 : 32'd2);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack_queue", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("ack_master", m1_ack, e.m);
        chk("ack_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk_i);
    mon();
  endtask

  task automatic set_m(input logic m, input logic req, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (m) begin
      m1_req = req; m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    sys_rst_i = 1'b1;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    repeat (2) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    @(negedge sys_clk_i);
  endtask

  // Single-master transaction with cycle-exact strobe and ack checks.
  task automatic run_txn(input logic m, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input bit drop_early);
    logic [15:0] exp_rd;
    int          base1;
    exp_rd = (rd && !wr) ? (addr ^ KEY) : 16'h0;
    base1  = n_ack1;
    push(m, exp_rd);
    set_m(m, 1'b1, rd, wr, addr, wdata);
    for (int c = 1; c <= int'(AC); c++) begin
      cyc();
      if (c == 1 && drop_early) set_m(m, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("access_io_rd", io_rd, rd && !wr);
      chk("access_io_wr", io_wr, wr);
      chk("access_io_addr", io_addr, addr);
      if (wr) chk("access_io_dout", io_dout, wdata);
      chk("access_ack_low", m ? m1_ack : m0_ack, 1'b0);
    end
    set_m(m, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cyc();
    chk("ack_cycle_ack", m ? m1_ack : m0_ack, 1'b1);
    chk("ack_cycle_strobes", {io_rd, io_wr}, 2'b00);
    chk("other_ack_low", m ? m0_ack : m1_ack, 1'b0);
    cyc();
    chk("post_ack_low", {m0_ack, m1_ack}, 2'b00);
    chk("other_rdata_hold", m ? m0_rdata : m1_rdata, model_rdata[~m]);
    if (drop_early) chk("drop_early_one_ack", n_ack1 - base1, 1);
  endtask

  initial begin
    int          base;
    logic        grant_seq [4];
    logic [15:0] a0, a1;
    n_checks = 0; n_pass = 0; n_ack = 0; n_ack1 = 0;

    do_reset();
    chk("rst_strobes", {io_rd, io_wr}, 2'b00);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_io_addr", io_addr, 16'h0);
    chk("rst_io_dout", io_dout, 16'h0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 32'h0);

    run_txn(1'b0, 1'b0, 1'b1, 16'h6901, 16'h00A5, 1'b0);  // m0 write
    run_txn(1'b1, 1'b1, 1'b0, 16'h6702, 16'h0000, 1'b0);  // m1 read -> 0x1234
    run_txn(1'b1, 1'b1, 1'b0, 16'h6710, 16'h0000, 1'b1);  // m1 drops req early
    run_txn(1'b0, 1'b1, 1'b1, 16'h6800, 16'h0007, 1'b0);  // rd+wr -> write only
    run_txn(1'b1, 1'b0, 1'b0, 16'h6C00, 16'h1111, 1'b0);  // no-op -> rdata 0

    // Held contention: round-robin or fixed priority after reset.
    do_reset();
`ifdef IO_BUS_ARB_FIXED_PRIO_EN
    grant_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    grant_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    a0 = 16'h6A00;
    a1 = 16'h6B10;
    for (int i = 0; i < 4; i++) push(grant_seq[i], (grant_seq[i] ? a1 : a0) ^ KEY);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, a0, 16'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, a1, 16'h0);
    base = n_ack;
    for (int i = 0; i < 60 && (n_ack - base) < 4; i++) cyc();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) cyc();
    chk("contention_ack_count", n_ack - base, 4);

    // Reset in the middle of an m0 write.
    set_m(1'b0, 1'b1, 1'b0, 1'b1, 16'h6E00, 16'hCAFE);
    cyc();
    chk("pre_rst_io_wr", io_wr, 1'b1);
    #2 sys_rst_i = 1'b1;
    #1;
    chk("mid_rst_strobes", {io_rd, io_wr}, 2'b00);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    base = n_ack;
    repeat (4) cyc();
    chk("mid_rst_no_ack", n_ack - base, 0);
    chk("mid_rst_idle_strobes", {io_rd, io_wr}, 2'b00);
    chk("mid_rst_io_addr", io_addr, 16'h0);

    // First contention after that reset must go to m0.
    push(1'b0, 16'h6A40 ^ KEY);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 16'h6A40, 16'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 16'h6B40, 16'h0);
    cyc();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("post_rst_grant_addr", io_addr, 16'h6A40);
    repeat (4) cyc();
    chk("post_rst_ack_count", n_ack - base, 1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
